// File: rtl/aftab_mem_width_bridge_if.sv
// Byte-serial core port plus word-wide memory bus of the AFTAB width bridge.
//   core side : coreRead/coreWrite/coreAddr/coreWData in, coreRData/coreReady out
//   control   : flush in, hitCnt/missCnt out
//   bus side  : busReq/busWe/busAddr/busByteEn/busWData out, busRData/busAck in
// slave  = the bridge's view; master = the surrounding core/memory environment.
interface aftab_mem_width_bridge_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BUS_BYTES = 4,
  parameter int unsigned CNT_W     = 16
);
  logic                     coreRead;
  logic                     coreWrite;
  logic [ADDR_W-1:0]        coreAddr;
  logic [7:0]               coreWData;
  logic [7:0]               coreRData;
  logic                     coreReady;
  logic                     flush;
  logic                     busReq;
  logic                     busWe;
  logic [ADDR_W-1:0]        busAddr;
  logic [BUS_BYTES-1:0]     busByteEn;
  logic [8*BUS_BYTES-1:0]   busWData;
  logic [8*BUS_BYTES-1:0]   busRData;
  logic                     busAck;
  logic [CNT_W-1:0]         hitCnt;
  logic [CNT_W-1:0]         missCnt;

  modport slave (
    input  coreRead, coreWrite, coreAddr, coreWData, flush, busRData, busAck,
    output coreRData, coreReady, busReq, busWe, busAddr, busByteEn, busWData,
           hitCnt, missCnt
  );

  modport master (
    output coreRead, coreWrite, coreAddr, coreWData, flush, busRData, busAck,
    input  coreRData, coreReady, busReq, busWe, busAddr, busByteEn, busWData,
           hitCnt, missCnt
  );
endinterface

// File: rtl/aftab_mem_width_bridge.sv
// Bridges the AFTAB byte-serial memory port to a BUS_BYTES-wide word bus.
// A one-line read buffer serves byte reads within the last fetched word;
// writes go straight through to the bus and patch the buffer on a match.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   mem_if : core port, flush, bus port and hit/miss counters (slave view)
module aftab_mem_width_bridge #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BUS_BYTES = 4,
  parameter int unsigned CNT_W     = 16
) (
  input logic                      clk,
  input logic                      rst,
  aftab_mem_width_bridge_if.slave  mem_if
);
  localparam int unsigned LANE_W = $clog2(BUS_BYTES);
  localparam int unsigned TAG_W  = ADDR_W - LANE_W;
  localparam int unsigned DATA_W = 8 * BUS_BYTES;

  typedef enum logic [1:0] {IDLE, BUS_RD, BUS_WR, RESP} state_e;

  state_e               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [DATA_W-1:0]    buf_q, buf_d;
  logic [TAG_W-1:0]     req_tag_q, req_tag_d;
  logic [LANE_W-1:0]    req_lane_q, req_lane_d;
  logic                 flush_seen_q, flush_seen_d;
  logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;
  logic                 bus_req_q, bus_req_d;
  logic                 bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]    bus_addr_q, bus_addr_d;
  logic [BUS_BYTES-1:0] bus_be_q, bus_be_d;
  logic [DATA_W-1:0]    bus_wdata_q, bus_wdata_d;
  logic                 core_ready_q, core_ready_d;
  logic [7:0]           core_rdata_q, core_rdata_d;

  logic [TAG_W-1:0]     in_tag;
  logic [LANE_W-1:0]    in_lane;
  logic                 hit_c;

  assign in_tag  = mem_if.coreAddr[ADDR_W-1:LANE_W];
  assign in_lane = mem_if.coreAddr[LANE_W-1:0];
  assign hit_c   = valid_q && (tag_q == in_tag);

  // Select byte lane l of a bus word (lane 0 = bits [7:0]).
  function automatic logic [7:0] lane_byte(input logic [DATA_W-1:0] d,
                                           input logic [LANE_W-1:0] l);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < BUS_BYTES; i++) begin
      if (l == LANE_W'(i)) r = d[i*8 +: 8];
    end
    return r;
  endfunction

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    buf_d        = buf_q;
    req_tag_d    = req_tag_q;
    req_lane_d   = req_lane_q;
    flush_seen_d = flush_seen_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    core_ready_d = 1'b0;
    core_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (mem_if.coreWrite) begin
          state_d     = BUS_WR;
          req_tag_d   = in_tag;
          req_lane_d  = in_lane;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = {in_tag, LANE_W'(0)};
          bus_be_d    = BUS_BYTES'(1) << in_lane;
          bus_wdata_d = {BUS_BYTES{mem_if.coreWData}};
        end else if (mem_if.coreRead) begin
          if (hit_c) begin
            state_d      = RESP;
            core_ready_d = 1'b1;
            core_rdata_d = lane_byte(buf_q, in_lane);
            hit_cnt_d    = sat_inc(hit_cnt_q);
          end else begin
            state_d      = BUS_RD;
            req_tag_d    = in_tag;
            req_lane_d   = in_lane;
            flush_seen_d = 1'b0;
            bus_req_d    = 1'b1;
            bus_we_d     = 1'b0;
            bus_addr_d   = {in_tag, LANE_W'(0)};
            bus_be_d     = '1;
            miss_cnt_d   = sat_inc(miss_cnt_q);
          end
        end
      end
      BUS_RD: begin
        if (mem_if.busAck) begin
          state_d      = RESP;
          bus_req_d    = 1'b0;
          buf_d        = mem_if.busRData;
          tag_d        = req_tag_q;
          // A flush anywhere in the fill window leaves the new line invalid.
          valid_d      = !(flush_seen_q || mem_if.flush);
          core_ready_d = 1'b1;
          core_rdata_d = lane_byte(mem_if.busRData, req_lane_q);
        end else if (mem_if.flush) begin
          flush_seen_d = 1'b1;
        end
      end
      BUS_WR: begin
        if (mem_if.busAck) begin
          state_d      = RESP;
          bus_req_d    = 1'b0;
          core_ready_d = 1'b1;
          // Keep the buffered line coherent with the written byte.
          if (valid_q && (tag_q == req_tag_q)) begin
            for (int unsigned i = 0; i < BUS_BYTES; i++) begin
              if (req_lane_q == LANE_W'(i)) buf_d[i*8 +: 8] = bus_wdata_q[7:0];
            end
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (mem_if.flush) valid_d = 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      tag_q        <= '0;
      buf_q        <= '0;
      req_tag_q    <= '0;
      req_lane_q   <= '0;
      flush_seen_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      core_ready_q <= 1'b0;
      core_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      buf_q        <= buf_d;
      req_tag_q    <= req_tag_d;
      req_lane_q   <= req_lane_d;
      flush_seen_q <= flush_seen_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      core_ready_q <= core_ready_d;
      core_rdata_q <= core_rdata_d;
    end
  end

  assign mem_if.busReq    = bus_req_q;
  assign mem_if.busWe     = bus_we_q;
  assign mem_if.busAddr   = bus_addr_q;
  assign mem_if.busByteEn = bus_be_q;
  assign mem_if.busWData  = bus_wdata_q;
  assign mem_if.coreReady = core_ready_q;
  assign mem_if.coreRData = core_rdata_q;
  assign mem_if.hitCnt    = hit_cnt_q;
  assign mem_if.missCnt   = miss_cnt_q;
endmodule

// File: tb/tb_aftab_mem_width_bridge.sv
// Self-checking bench for aftab_mem_width_bridge: directed scenarios plus
// randomized byte traffic against a memory/buffer reference model.
module tb_aftab_mem_width_bridge;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned BUS_BYTES = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int          CMAX      = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  aftab_mem_width_bridge_if #(.ADDR_W(ADDR_W), .BUS_BYTES(BUS_BYTES), .CNT_W(CNT_W)) bif ();

  aftab_mem_width_bridge #(.ADDR_W(ADDR_W), .BUS_BYTES(BUS_BYTES), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .mem_if (bif)
  );

  int errors = 0;
  int checks = 0;

  // Bus-side memory (responder) and architectural reference (main thread).
  logic [7:0] mem     [1024];
  logic [7:0] ref_mem [1024];

  int resp_lat    = 1;
  int fl_rd_tok   = 0;
  int fl_rd_done  = 0;
  int fl_idle_tok = 0;
  int fl_idle_done = 0;

  int          nbus = 0;
  logic        last_we;
  logic [31:0] last_addr;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  int          last_cycles;
  bit          stable_ok;

  bit          m_valid;
  logic [29:0] m_tag;
  int          m_hits;
  int          m_misses;

  logic [31:0] bases [4] = '{32'h100, 32'h104, 32'h200, 32'h3FC};

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] w;
    if ((i >> 2) == 'h40)      w = 32'hDDCCBBAA;
    else if ((i >> 2) == 'h80) w = 32'h44332211;
    else return 8'(i * 37 + 11);
    return w[(i & 3) * 8 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit wr, input logic [31:0] a, input logic [7:0] wd,
                        input int lat, input bit fl, input string tag,
                        output logic [7:0] rd, output int lt);
    bit exp_hit;
    logic [7:0] exp_rd;
    int nb0;
    int n;
    bit got;
    exp_hit = !wr && m_valid && (m_tag == a[31:2]);
    exp_rd  = wr ? 8'h00 : ref_mem[a[9:0]];
    nb0 = nbus;
    resp_lat = lat;
    if (fl) fl_rd_tok++;
    bif.coreAddr  = a;
    bif.coreWData = wd;
    bif.coreWrite = wr;
    bif.coreRead  = !wr;
    n = 0; got = 0; rd = 8'h00;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (bif.coreReady) begin
        got = 1;
        rd  = bif.coreRData;
      end
    end
    lt = n - 1;
    chk({tag, "_ready"}, 64'(got), 64'(1));
    chk({tag, "_latency"}, 64'(lt), 64'(exp_hit ? 1 : lat + 1));
    chk({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
    chk({tag, "_buscount"}, 64'(nbus - nb0), 64'(exp_hit ? 0 : 1));
    if (!exp_hit) begin
      chk({tag, "_buswe"}, 64'(last_we), 64'(wr));
      chk({tag, "_busaddr"}, 64'(last_addr), 64'({a[31:2], 2'b00}));
      chk({tag, "_busbe"}, 64'(last_be), 64'(wr ? (4'b0001 << a[1:0]) : 4'hF));
      chk({tag, "_buscycles"}, 64'(last_cycles), 64'(lat));
      chk({tag, "_busstable"}, 64'(stable_ok), 64'(1));
      if (wr) chk({tag, "_buswdata"}, 64'(last_wdata), 64'({4{wd}}));
    end
    if (wr) begin
      ref_mem[a[9:0]] = wd;
      if (fl) m_valid = 0;
    end else if (exp_hit) begin
      if (m_hits < CMAX) m_hits++;
    end else begin
      if (m_misses < CMAX) m_misses++;
      m_valid = !fl;
      m_tag   = a[31:2];
    end
    @(posedge clk); #1;
    bif.coreRead  = 0;
    bif.coreWrite = 0;
    chk({tag, "_hitcnt"}, 64'(bif.hitCnt), 64'(m_hits));
    chk({tag, "_misscnt"}, 64'(bif.missCnt), 64'(m_misses));
  endtask

  task automatic idle_flush();
    @(negedge clk);
    fl_idle_tok++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_valid = 0;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Bus memory responder: acks the resp_lat-th cycle of each request.
  initial begin
    int cyc;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wd;
    bit          cur_stable;
    bif.busAck   = 0;
    bif.busRData = '0;
    bif.flush    = 0;
    cyc = 0; cur_stable = 1;
    cap_we = 0; cap_addr = '0; cap_be = '0; cap_wd = '0;
    stable_ok = 1;
    for (int i = 0; i < 1024; i++) mem[i] = init_byte(i);
    forever begin
      @(posedge clk); #1;
      bif.busAck = 0;
      bif.flush  = 0;
      if (fl_idle_tok != fl_idle_done) begin
        bif.flush = 1;
        fl_idle_done = fl_idle_tok;
      end
      if (bif.busReq) begin
        cyc++;
        if (cyc == 1) begin
          cap_we = bif.busWe; cap_addr = bif.busAddr;
          cap_be = bif.busByteEn; cap_wd = bif.busWData;
          cur_stable = 1;
          if (fl_rd_tok != fl_rd_done) begin
            bif.flush = 1;
            fl_rd_done = fl_rd_tok;
          end
        end else if (bif.busWe !== cap_we || bif.busAddr !== cap_addr ||
                     bif.busByteEn !== cap_be || bif.busWData !== cap_wd) begin
          cur_stable = 0;
        end
        if (cyc == resp_lat) begin
          bif.busAck = 1;
          if (cap_we) begin
            for (int i = 0; i < 4; i++)
              if (cap_be[i]) mem[{cap_addr[9:2], 2'(i)}] = cap_wd[8*i +: 8];
          end else begin
            bif.busRData = {mem[{cap_addr[9:2], 2'd3}], mem[{cap_addr[9:2], 2'd2}],
                            mem[{cap_addr[9:2], 2'd1}], mem[{cap_addr[9:2], 2'd0}]};
          end
          last_we = cap_we; last_addr = cap_addr; last_be = cap_be;
          last_wdata = cap_wd; last_cycles = cyc; stable_ok = cur_stable;
          nbus++;
        end
      end else begin
        cyc = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int lt;
    int nb;
    rst = 1;
    bif.coreRead = 0; bif.coreWrite = 0; bif.coreAddr = '0; bif.coreWData = '0;
    m_valid = 0; m_tag = '0; m_hits = 0; m_misses = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);

    // Reset asserted between edges clears every output at once.
    #3 rst = 0;
    #1;
    chk("rst_busreq",  64'(bif.busReq), 64'(0));
    chk("rst_buswe",   64'(bif.busWe), 64'(0));
    chk("rst_busaddr", 64'(bif.busAddr), 64'(0));
    chk("rst_busbe",   64'(bif.busByteEn), 64'(0));
    chk("rst_ready",   64'(bif.coreReady), 64'(0));
    chk("rst_rdata",   64'(bif.coreRData), 64'(0));
    chk("rst_hitcnt",  64'(bif.hitCnt), 64'(0));
    chk("rst_misscnt", 64'(bif.missCnt), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1;
    @(posedge clk); #1;

    // Miss then in-word hit.
    access(0, 32'h100, 8'h00, 3, 0, "t2_rd100", rd, lt);
    chk("t2_rd100_value", 64'(rd), 64'(8'hAA));
    chk("t2_rd100_cycles", 64'(last_cycles), 64'(3));
    access(0, 32'h103, 8'h00, 3, 0, "t2_rd103", rd, lt);
    chk("t2_rd103_value", 64'(rd), 64'(8'hDD));
    chk("t2_rd103_lat", 64'(lt), 64'(1));
    chk("t2_hitcnt", 64'(bif.hitCnt), 64'(1));
    chk("t2_misscnt", 64'(bif.missCnt), 64'(1));

    // Write-through patches the buffered line.
    access(1, 32'h101, 8'h55, 2, 0, "t3_wr101", rd, lt);
    chk("t3_be", 64'(last_be), 64'(4'b0010));
    chk("t3_wdata", 64'(last_wdata), 64'(32'h55555555));
    access(0, 32'h101, 8'h00, 2, 0, "t3_rd101", rd, lt);
    chk("t3_rd101_value", 64'(rd), 64'(8'h55));

    // Flush during a fill: data delivered but line left invalid.
    access(0, 32'h200, 8'h00, 2, 1, "t4_rd200", rd, lt);
    chk("t4_rd200_value", 64'(rd), 64'(8'h11));
    nb = nbus;
    access(0, 32'h201, 8'h00, 2, 0, "t4_rd201", rd, lt);
    chk("t4_rd201_missed", 64'(nbus - nb), 64'(1));
    chk("t4_rd201_value", 64'(rd), 64'(8'h22));

    // Randomized traffic over a few words.
    for (int k = 0; k < 48; k++) begin
      logic [31:0] a;
      bit wr;
      bit fl;
      bit pred_bus;
      int lat;
      a   = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
      wr  = ($urandom_range(0, 3) == 0);
      lat = $urandom_range(1, 4);
      pred_bus = wr || !(m_valid && (m_tag == a[31:2]));
      fl  = pred_bus && ($urandom_range(0, 7) == 0);
      access(wr, a, 8'($urandom), lat, fl, "rnd", rd, lt);
      if ($urandom_range(0, 7) == 0) idle_flush();
    end

    // Reset during a bus write abandons it.
    resp_lat = 50;
    bif.coreAddr = 32'h100; bif.coreWData = 8'h77; bif.coreWrite = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_busreq_before", 64'(bif.busReq), 64'(1));
    #2 rst = 0;
    #1;
    chk("t5_busreq_after", 64'(bif.busReq), 64'(0));
    chk("t5_buswe_after", 64'(bif.busWe), 64'(0));
    chk("t5_busbe_after", 64'(bif.busByteEn), 64'(0));
    chk("t5_wdata_after", 64'(bif.busWData), 64'(0));
    chk("t5_hitcnt_after", 64'(bif.hitCnt), 64'(0));
    chk("t5_misscnt_after", 64'(bif.missCnt), 64'(0));
    bif.coreWrite = 0;
    @(negedge clk);
    rst = 1;
    m_valid = 0; m_hits = 0; m_misses = 0;
    @(posedge clk); #1;
    nb = nbus;
    access(0, 32'h100, 8'h00, 2, 0, "t5_rd100", rd, lt);
    chk("t5_rd100_missed", 64'(nbus - nb), 64'(1));
    chk("t5_misscnt", 64'(bif.missCnt), 64'(1));

    // Hit counter saturates.
    for (int k = 0; k < 20; k++) begin
      access(0, 32'h100 + 32'(k % 4), 8'h00, 1, 0, "t6_hit", rd, lt);
    end
    chk("t6_hitcnt_sat", 64'(bif.hitCnt), 64'(15));
    access(0, 32'h102, 8'h00, 1, 0, "t6_hit_extra", rd, lt);
    chk("t6_hitcnt_stays", 64'(bif.hitCnt), 64'(15));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
